// File: rtl/req4_grant_arbiter.sv
// Four-requester arbiter that holds a registered one-hot grant until release.
// Supports fixed priority (3 > 2 > 1 > 0) or rotating priority, with a hold budget.
module req4_grant_arbiter #(
    parameter int ROUND_ROBIN = 0,
    parameter int HOLD_MAX    = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] req,
    input  logic       done,
    output logic [3:0] grant,
    output logic [1:0] grant_id,
    output logic       grant_valid,
    output logic       timeout
);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t     state;
    logic [7:0] hold_cnt;
    logic [1:0] last_id;
    logic [1:0] search_start;
    logic [1:0] winner;
    logic       owner_req;
    logic       hold_expired;
    logic       release_now;

    // Descending search from start with wrap-around; first requester found wins.
    function automatic logic [1:0] pick(input logic [3:0] r, input logic [1:0] start);
        logic [1:0] idx;
        logic [1:0] win;
        logic       found;
        win   = 2'd0;
        found = 1'b0;
        for (int i = 0; i < 4; i++) begin
            idx = start - 2'(i);
            if (!found && r[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end
        return win;
    endfunction

    always_comb begin
        search_start = (ROUND_ROBIN != 0) ? (last_id - 2'd1) : 2'd3;
        winner       = pick(req, search_start);
        owner_req    = req[grant_id];
        hold_expired = (hold_cnt == 8'(HOLD_MAX));
        release_now  = done || !owner_req || hold_expired;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            grant       <= 4'b0000;
            grant_id    <= 2'd0;
            grant_valid <= 1'b0;
            timeout     <= 1'b0;
            hold_cnt    <= 8'd0;
            last_id     <= 2'd0;
        end else begin
            case (state)
                IDLE: begin
                    timeout <= 1'b0;
                    if (req != 4'b0000) begin
                        state       <= BUSY;
                        grant       <= 4'b0001 << winner;
                        grant_id    <= winner;
                        grant_valid <= 1'b1;
                        last_id     <= winner;
                        hold_cnt    <= 8'd1;
                    end
                end
                BUSY: begin
                    if (release_now) begin
                        state       <= IDLE;
                        grant       <= 4'b0000;
                        grant_valid <= 1'b0;
                        // Timeout only flags a release nothing else would have caused.
                        timeout     <= hold_expired && !done && owner_req;
                    end else begin
                        timeout <= 1'b0;
                        if (hold_cnt != 8'hFF) begin
                            hold_cnt <= hold_cnt + 8'd1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_req4_grant_arbiter.sv
// Directed bench: instance a is fixed priority with HOLD_MAX=4,
// instance b is round robin with HOLD_MAX=3.
module tb_req4_grant_arbiter;

    logic       clk;
    logic       reset_a, reset_b;
    logic [3:0] req_a, req_b;
    logic       done_a, done_b;
    logic [3:0] grant_a, grant_b;
    logic [1:0] grant_id_a, grant_id_b;
    logic       grant_valid_a, grant_valid_b;
    logic       timeout_a, timeout_b;

    int errors = 0;
    int checks = 0;

    req4_grant_arbiter #(.ROUND_ROBIN(0), .HOLD_MAX(4)) dut_a (
        .clk(clk), .reset(reset_a), .req(req_a), .done(done_a),
        .grant(grant_a), .grant_id(grant_id_a), .grant_valid(grant_valid_a), .timeout(timeout_a)
    );

    req4_grant_arbiter #(.ROUND_ROBIN(1), .HOLD_MAX(3)) dut_b (
        .clk(clk), .reset(reset_b), .req(req_b), .done(done_b),
        .grant(grant_b), .grant_id(grant_id_b), .grant_valid(grant_valid_b), .timeout(timeout_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_a(input string tag, input logic [3:0] g, input logic [1:0] id,
                         input logic v, input logic t);
        chk({tag, ".grant"}, 8'(grant_a), 8'(g));
        if (v) chk({tag, ".id"}, 8'(grant_id_a), 8'(id));
        chk({tag, ".valid"}, 8'(grant_valid_a), 8'(v));
        chk({tag, ".timeout"}, 8'(timeout_a), 8'(t));
    endtask

    task automatic chk_b(input string tag, input logic [3:0] g, input logic [1:0] id,
                         input logic v, input logic t);
        chk({tag, ".grant"}, 8'(grant_b), 8'(g));
        if (v) chk({tag, ".id"}, 8'(grant_id_b), 8'(id));
        chk({tag, ".valid"}, 8'(grant_valid_b), 8'(v));
        chk({tag, ".timeout"}, 8'(timeout_b), 8'(t));
    endtask

    initial begin
        reset_a = 1'b1; reset_b = 1'b1;
        req_a = 4'b0000; req_b = 4'b0000;
        done_a = 1'b0; done_b = 1'b0;
        tick();
        tick();
        chk_a("a_reset", 4'b0000, 2'd0, 1'b0, 1'b0);
        chk("a_reset.id", 8'(grant_id_a), 8'd0);
        chk_b("b_reset", 4'b0000, 2'd0, 1'b0, 1'b0);
        reset_a = 1'b0; reset_b = 1'b0;
        tick();
        chk_a("a_post_reset", 4'b0000, 2'd0, 1'b0, 1'b0);

        // done in IDLE with no requests changes nothing
        done_a = 1'b1;
        tick();
        done_a = 1'b0;
        chk_a("a_done_idle", 4'b0000, 2'd0, 1'b0, 1'b0);
        chk("a_done_idle.id", 8'(grant_id_a), 8'd0);

        // Fixed priority: 0110 -> requester 2
        req_a = 4'b0110;
        tick();
        chk_a("a_fp_grant", 4'b0100, 2'd2, 1'b1, 1'b0);
        done_a = 1'b1;
        tick();
        done_a = 1'b0;
        chk_a("a_fp_release", 4'b0000, 2'd0, 1'b0, 1'b0);
        chk("a_fp_id_held", 8'(grant_id_a), 8'd2);
        tick();
        chk_a("a_fp_regrant", 4'b0100, 2'd2, 1'b1, 1'b0);
        done_a = 1'b1;
        tick();
        done_a = 1'b0;
        chk_a("a_fp_release2", 4'b0000, 2'd0, 1'b0, 1'b0);

        // Timeout with HOLD_MAX=4
        req_a = 4'b0001;
        tick();
        chk_a("a_to_c1", 4'b0001, 2'd0, 1'b1, 1'b0);
        tick();
        chk_a("a_to_c2", 4'b0001, 2'd0, 1'b1, 1'b0);
        tick();
        chk_a("a_to_c3", 4'b0001, 2'd0, 1'b1, 1'b0);
        tick();
        chk_a("a_to_c4", 4'b0001, 2'd0, 1'b1, 1'b0);
        tick();
        chk_a("a_to_fire", 4'b0000, 2'd0, 1'b0, 1'b1);
        tick();
        chk_a("a_to_regrant", 4'b0001, 2'd0, 1'b1, 1'b0);
        req_a = 4'b0000;
        tick();
        chk_a("a_drop_release", 4'b0000, 2'd0, 1'b0, 1'b0);

        // Highest index wins, then request drop releases and lower requester follows
        req_a = 4'b1011;
        tick();
        chk_a("a_fp_top", 4'b1000, 2'd3, 1'b1, 1'b0);
        req_a = 4'b0011;
        tick();
        chk_a("a_fp_drop", 4'b0000, 2'd0, 1'b0, 1'b0);
        tick();
        chk_a("a_fp_next", 4'b0010, 2'd1, 1'b1, 1'b0);

        // Round robin rotation with all requesting
        req_b = 4'b1111;
        tick();
        chk_b("b_rr_g0", 4'b1000, 2'd3, 1'b1, 1'b0);
        done_b = 1'b1; tick(); done_b = 1'b0;
        chk_b("b_rr_i0", 4'b0000, 2'd0, 1'b0, 1'b0);
        tick();
        chk_b("b_rr_g1", 4'b0100, 2'd2, 1'b1, 1'b0);
        done_b = 1'b1; tick(); done_b = 1'b0;
        chk_b("b_rr_i1", 4'b0000, 2'd0, 1'b0, 1'b0);
        tick();
        chk_b("b_rr_g2", 4'b0010, 2'd1, 1'b1, 1'b0);
        done_b = 1'b1; tick(); done_b = 1'b0;
        chk_b("b_rr_i2", 4'b0000, 2'd0, 1'b0, 1'b0);
        tick();
        chk_b("b_rr_g3", 4'b0001, 2'd0, 1'b1, 1'b0);
        done_b = 1'b1; tick(); done_b = 1'b0;
        chk_b("b_rr_i3", 4'b0000, 2'd0, 1'b0, 1'b0);
        tick();
        chk_b("b_rr_g4", 4'b1000, 2'd3, 1'b1, 1'b0);
        done_b = 1'b1; tick(); done_b = 1'b0;
        chk_b("b_rr_i4", 4'b0000, 2'd0, 1'b0, 1'b0);

        // done coincides with hold budget (HOLD_MAX=3): no timeout
        req_b = 4'b0100;
        tick();
        chk_b("b_sim_g", 4'b0100, 2'd2, 1'b1, 1'b0);
        tick();
        tick();
        chk_b("b_sim_hold", 4'b0100, 2'd2, 1'b1, 1'b0);
        done_b = 1'b1;
        tick();
        done_b = 1'b0;
        chk_b("b_sim_release", 4'b0000, 2'd0, 1'b0, 1'b0);

        // Owner 3 drops its request while requester 0 is active
        req_b = 4'b1000;
        tick();
        chk_b("b_drop_g3", 4'b1000, 2'd3, 1'b1, 1'b0);
        req_b = 4'b1001;
        tick();
        chk_b("b_drop_keep", 4'b1000, 2'd3, 1'b1, 1'b0);
        req_b = 4'b0001;
        tick();
        chk_b("b_drop_release", 4'b0000, 2'd0, 1'b0, 1'b0);
        tick();
        chk_b("b_drop_next", 4'b0001, 2'd0, 1'b1, 1'b0);
        done_b = 1'b1; tick(); done_b = 1'b0;

        // Async reset between edges while requester 1 owns the grant
        req_b = 4'b0010;
        tick();
        chk_b("b_ar_g1", 4'b0010, 2'd1, 1'b1, 1'b0);
        #2;
        reset_b = 1'b1;
        #1;
        chk_b("b_ar_async", 4'b0000, 2'd0, 1'b0, 1'b0);
        chk("b_ar_async.id", 8'(grant_id_b), 8'd0);
        tick();
        chk_b("b_ar_held", 4'b0000, 2'd0, 1'b0, 1'b0);
        reset_b = 1'b0;
        req_b = 4'b1111;
        tick();
        chk_b("b_ar_restart", 4'b1000, 2'd3, 1'b1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
